ram_sdp_be: RTL and testbench
=============================

Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port RAM: one write port and one independent read port in a single clock domain.
- Adds per-byte write enables, a selectable read latency (1 or 2 cycles) with a read-valid strobe, and a defined read/write collision policy.
- Optional hardware clear engine zeroes the whole array after reset.
- General-purpose on-chip storage for data buffers and lookup tables; it supersedes the single-port read/write RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2 only.
- COLLISION_MODE, 0, same-address read+write in one cycle: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents are not reset.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- init_busy  output  1  high while reset is held or the clear engine runs; both ports are ignored while high.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  output  1  one-cycle pulse when rd_data carries a new result.

Behaviour:
- Reset: when rst is sampled high, rd_data=0, rd_valid=0, all read-pipeline stages are invalidated, and the clear counter is set to 0.
- init_busy during reset: 1 while rst is high if CLEAR_ON_RESET=1; otherwise 0.
- Reset mid-operation (mid-read or mid-clear): in-flight reads are discarded with no rd_valid, and the clear restarts from address 0.
- Clear engine (CLEAR_ON_RESET=1):
  - Starting the first cycle after rst is sampled low, writes all-zero to address k in cycle k, for k = 0..DEPTH-1.
  - init_busy falls in the cycle after address DEPTH-1 is written, i.e. exactly DEPTH cycles of busy after reset release.
  - Host wr_en and rd_en are ignored while busy: no write, no read accepted, no rd_valid.
- Write: on a rising edge with wr_en=1 and init_busy=0, each byte i with wr_be[i]=1 takes wr_data at that byte; other bytes are unchanged. wr_be=0 is a legal no-op.
- Read accept: occurs on a rising edge with rd_en=1 and init_busy=0, using rd_addr.
  - RD_LATENCY=1: rd_data is updated and rd_valid=1 in the cycle after the accept edge.
  - RD_LATENCY=2: one extra output register; result appears two cycles after the accept edge.
  - Back-to-back accepts give back-to-back rd_valid pulses (full throughput, no stalls).
- Read outputs with no accept: rd_valid=0 and rd_data holds its last value.
- Collision (accepted read and write to the same address on the same edge):
  - COLLISION_MODE=0: returns the pre-write word.
  - COLLISION_MODE=1: returns a merge, wr_data on enabled bytes and old data on the rest.
  - Only same-edge collisions are special; a write on any later edge never alters a read already accepted, for either latency.
- Different-address read and write on the same edge proceed independently.
- Address wrap: none; every address 0..DEPTH-1 is valid, and no out-of-range case exists.
- Illegal parameters (RD_LATENCY not 1 or 2, DATA_WIDTH not a multiple of 8, ADDR_WIDTH < 1) are elaboration-time errors.

Test Plan:
- Clear engine: ADDR_WIDTH=4, CLEAR_ON_RESET=1; hold rst 3 cycles then release -> init_busy high for exactly 16 cycles after release; reading addresses 0..15 then returns 0x00000000.
- Busy lockout: assert wr_en at addr 5 with 0xDEADBEEF during busy -> after busy clears, read of addr 5 returns 0x00000000.
- Byte enables:
  - Write 0x11223344 at addr 7 with wr_be=4'b1111.
  - Then write 0xAABBCCDD at addr 7 with wr_be=4'b0101.
  - Read addr 7 -> 0x11BB33DD.
- Latency and throughput, RD_LATENCY=1 and 2:
  - Four consecutive reads of addresses 0..3 holding 0xA0..0xA3.
  - Required response: four consecutive rd_valid pulses starting 1 (resp. 2) cycles after the first accept, with data in order.
  - rd_data holds 0xA3 afterwards.
- Collision:
  - addr 9 holds 0x12345678; on the same edge, write 0xFFFFFFFF with wr_be=4'b0011 and read addr 9.
  - COLLISION_MODE=0 returns 0x12345678; COLLISION_MODE=1 returns 0x1234FFFF.
  - A following read returns 0x1234FFFF in both modes.
- Mid-operation reset, RD_LATENCY=2:
  - Assert rst one cycle after a read accept -> no rd_valid pulse for that read, and rd_data is 0.
  - Clear restarts: init_busy high for DEPTH cycles after release.

Source files
------------

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable same-address collision policy and an optional post-reset clear engine.
module ram_sdp_be #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned COLLISION_MODE = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  generate
    if ((RD_LATENCY != 1 && RD_LATENCY != 2) || (DATA_WIDTH % 8 != 0) ||
        (DATA_WIDTH == 0) || (ADDR_WIDTH < 1)) begin : g_bad_param
      $error("ram_sdp_be: illegal parameter combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  clr_we_c;
  logic [ADDR_WIDTH-1:0] clr_addr_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Host ports are locked out while reset is held or the clear engine runs.
  assign wr_acc_c  = wr_en && !busy && !rst;
  assign rd_acc_c  = rd_en && !busy && !rst;
  assign init_busy = busy;

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      logic [ADDR_WIDTH-1:0] clr_cnt;

      // Walks every address once after reset release; busy drops after the last one.
      always_ff @(posedge clk) begin
        if (rst) begin
          busy    <= 1'b1;
          clr_cnt <= '0;
        end else if (busy) begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (&clr_cnt) begin
            busy <= 1'b0;
          end
        end
      end

      assign clr_we_c   = busy && !rst;
      assign clr_addr_c = clr_cnt;
    end else begin : g_no_clear
      assign busy       = 1'b0;
      assign clr_we_c   = 1'b0;
      assign clr_addr_c = '0;
    end
  endgenerate

  // Storage array: clear engine has priority, host writes are byte-masked.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_addr_c] <= '0;
    end else if (wr_acc_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word, optionally forwarding same-edge write bytes in write-first mode.
  always_comb begin
    rd_word_c = mem[rd_addr];
    if (COLLISION_MODE != 0 && wr_acc_c && (wr_addr == rd_addr)) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          rd_word_c[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc_c;
          if (rd_acc_c) begin
            rd_data <= rd_word_c;
          end
        end
      end
    end else begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      // Word is captured on the accept edge so later writes cannot disturb it.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          s1_valid <= rd_acc_c;
          if (rd_acc_c) begin
            s1_data <= rd_word_c;
          end
          rd_valid <= s1_valid;
          if (s1_valid) begin
            rd_data <= s1_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (latency 1/read-first, latency 2/write-first)
// share stimulus; a per-instance behavioural model is compared every cycle.
module tb_ram_sdp_be;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          a_busy, b_busy, a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;

  int n_assert = 0;
  int n_fail   = 0;

  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1),
               .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .init_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid)
  );

  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2),
               .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .init_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Model state: instance 0 = latency 1 / old data, instance 1 = latency 2 / merged data.
  logic [31:0] m_mem  [2][DEPTH];
  bit          m_busy [2];
  int          m_left [2];
  bit          sch_v  [2][4];
  logic [31:0] sch_d  [2][4];
  bit          e_valid[2];
  logic [31:0] e_data [2];
  int          cyc     = 0;
  bit          started = 0;

  // Results are scheduled into the slot of the edge on which they must appear.
  task automatic model_step();
    logic [31:0] w;
    int s;
    cyc++;
    if (rst) started = 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) sch_v[i][k] = 0;
        for (int a = 0; a < DEPTH; a++) m_mem[i][a] = 32'h0;
        e_valid[i] = 0;
        e_data[i]  = 32'h0;
        m_busy[i]  = 1;
        m_left[i]  = DEPTH;
      end else if (started) begin
        if (rd_en && !m_busy[i]) begin
          w = m_mem[i][rd_addr];
          if (i == 1 && wr_en && wr_addr == rd_addr)
            for (int b = 0; b < 4; b++) if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
          s = (cyc + i) % 4;
          sch_v[i][s] = 1;
          sch_d[i][s] = w;
        end
        if (wr_en && !m_busy[i])
          for (int b = 0; b < 4; b++)
            if (wr_be[b]) m_mem[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        if (m_busy[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) m_busy[i] = 0;
        end
        s = cyc % 4;
        e_valid[i] = sch_v[i][s];
        if (sch_v[i][s]) e_data[i] = sch_d[i][s];
        sch_v[i][s] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("a_busy",  32'(a_busy),  32'(m_busy[0]));
      check("a_valid", 32'(a_valid), 32'(e_valid[0]));
      check("a_data",  a_data,       e_data[0]);
      check("b_busy",  32'(b_busy),  32'(m_busy[1]));
      check("b_valid", 32'(b_valid), 32'(e_valid[1]));
      check("b_data",  b_data,       e_data[1]);
    end
  end

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_be = 4'h0;
  endtask

  // Counts busy cycles from reset release while hammering addr 5 with writes/reads.
  task automatic wait_busy(input string name);
    int cnt = 0;
    while (a_busy === 1'b1 && cnt < 100) begin
      cnt++;
      wr_en   = (cnt < 8);
      wr_addr = 4'd5;
      wr_data = 32'hDEADBEEF;
      wr_be   = 4'hF;
      rd_en   = (cnt < 8);
      rd_addr = 4'd5;
      @(negedge clk);
    end
    idle();
    check(name, 32'(cnt), 32'd16);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    @(negedge clk);
    idle();
  endtask

  // Single read; any write fields set by the caller apply to the same edge.
  task automatic rd1(input string name, input logic [3:0] addr,
                     input logic [31:0] ea, input logic [31:0] eb);
    rd_en   = 1'b1;
    rd_addr = addr;
    @(negedge clk);
    idle();
    check({name, "_a_valid"}, 32'(a_valid), 32'd1);
    check({name, "_a_data"},  a_data, ea);
    @(negedge clk);
    check({name, "_b_valid"}, 32'(b_valid), 32'd1);
    check({name, "_b_data"},  b_data, eb);
  endtask

  initial begin
    rst     = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_busy("busy_len_1");

    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    rd1("lockout_addr5", 4'd5, 32'h0, 32'h0);

    for (int k = 0; k < 4; k++) wr(4'(k), 32'hA0 + 32'(k), 4'hF);
    wr(4'd7, 32'h11223344, 4'hF);
    wr(4'd7, 32'hAABBCCDD, 4'b0101);
    wr(4'd9, 32'h12345678, 4'hF);
    wr(4'd8, 32'hCAFEF00D, 4'h0);
    rd1("byte_en", 4'd7, 32'h11BB33DD, 32'h11BB33DD);
    rd1("be_zero_noop", 4'd8, 32'h0, 32'h0);

    // Back-to-back burst: A returns at j=0..3, B at j=1..4.
    for (int j = 0; j < 6; j++) begin
      rd_en   = (j < 4);
      rd_addr = 4'(j);
      @(negedge clk);
      check("burst_a_valid", 32'(a_valid), 32'(j < 4));
      if (j < 4) check("burst_a_data", a_data, 32'hA0 + 32'(j));
      check("burst_b_valid", 32'(b_valid), 32'(j >= 1 && j <= 4));
      if (j >= 1 && j <= 4) check("burst_b_data", b_data, 32'hA0 + 32'(j - 1));
    end
    idle();
    check("hold_a", a_data, 32'hA3);
    check("hold_b", b_data, 32'hA3);

    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 32'hFFFFFFFF;
    wr_be   = 4'b0011;
    rd1("collide", 4'd9, 32'h12345678, 32'h1234FFFF);
    rd1("after_collide", 4'd9, 32'h1234FFFF, 32'h1234FFFF);

    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = 32'h00000055;
    wr_be   = 4'hF;
    rd1("diff_addr", 4'd3, 32'hA3, 32'hA3);
    rd1("diff_addr_wr", 4'd4, 32'h55, 32'h55);

    // Write one edge after an accepted read must not alter that read.
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    @(negedge clk);
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 32'h0;
    wr_be   = 4'hF;
    check("late_wr_a", a_data, 32'h1234FFFF);
    @(negedge clk);
    idle();
    check("late_wr_b_valid", 32'(b_valid), 32'd1);
    check("late_wr_b", b_data, 32'h1234FFFF);
    rd1("late_wr_applied", 4'd9, 32'h0, 32'h0);

    // Reset one cycle after an accept discards the in-flight latency-2 read.
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b1;
    check("midrst_a_data", a_data, 32'h11BB33DD);
    @(negedge clk);
    check("midrst_b_valid", 32'(b_valid), 32'd0);
    check("midrst_b_data",  b_data, 32'h0);
    check("midrst_a_data0", a_data, 32'h0);
    @(negedge clk);
    check("midrst_b_valid2", 32'(b_valid), 32'd0);
    rst = 1'b0;
    wait_busy("busy_len_2");
    rd1("post_clear", 4'd7, 32'h0, 32'h0);

    idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
